// File: rtl/spi_log_serializer.sv
// spi_log_serializer
// Collects fixed-width log records from several channels, queues them in a
// record FIFO and transmits each one as a framed byte packet (header followed
// by the payload, most significant byte first) under a ready/strobe handshake.
// Lost records are reported in-band by a drop-marker packet (header 8'hFF)
// whose payload LSB carries the number of records lost since the last marker.

module spi_log_serializer #(
    parameter int CHANNELS     = 2,
    parameter int RECORD_BYTES = 4,
    parameter int DEPTH        = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [CHANNELS-1:0]                log_strobe,
    input  logic [CHANNELS*RECORD_BYTES*8-1:0] log_data,
    input  logic                               uart_txd_ready,
    output logic [7:0]                         uart_txd,
    output logic                               uart_txd_strobe,
    output logic [$clog2(DEPTH):0]             fifo_level,
    output logic [7:0]                         drops,
    output logic                               busy
);

    localparam int PAYLOAD_W = RECORD_BYTES * 8;
    localparam int ENTRY_W   = PAYLOAD_W + 8;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    // Byte counter must hold RECORD_BYTES+1 (header plus payload).
    localparam int CNT_W     = $clog2(RECORD_BYTES + 2);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [7:0]       MARKER_HDR = 8'hFF;
    localparam logic [3:0]       RECORD_TAG = 4'hA;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    // Per-channel one-record holding registers
    logic [CHANNELS-1:0]  pend_valid_q;
    logic [PAYLOAD_W-1:0] pend_data_q [CHANNELS];

    // Lowest-index pending record
    logic                 sel_valid;
    logic [CHANNELS-1:0]  sel_mask;
    logic [3:0]           sel_id;
    logic [PAYLOAD_W-1:0] sel_data;

    // FIFO write-stage decisions
    logic                 drops_pending;
    logic                 can_write;
    logic                 marker_push;
    logic                 normal_push;
    logic                 fifo_wr;
    logic                 stage_drop;
    logic [CHANNELS-1:0]  pend_clear;
    logic [PAYLOAD_W-1:0] marker_payload;
    logic [ENTRY_W-1:0]   wr_entry;

    // Capture decisions
    logic [CHANNELS-1:0]  load_mask;
    logic [4:0]           capture_drops;
    logic [4:0]           drop_total;
    logic [8:0]           drops_sum;
    logic [7:0]           drops_next;
    logic [7:0]           drops_q;

    // Record FIFO
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [ENTRY_W-1:0]   rd_data_q;
    logic                 fifo_rd;

    // Output FSM and datapath
    state_t               state_q;
    state_t               state_d;
    logic                 send_byte;
    logic [ENTRY_W-1:0]   shift_q;
    logic [CNT_W-1:0]     bytes_left_q;
    logic [7:0]           txd_hold_q;

    // ------------------------------------------------------------------
    // Pending-record selection: lowest-index full register wins
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_mask  = '0;
        sel_id    = '0;
        sel_data  = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pend_valid_q[c]) begin
                sel_valid   = 1'b1;
                sel_mask    = '0;
                sel_mask[c] = 1'b1;
                sel_id      = 4'(c);
                sel_data    = pend_data_q[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO write stage: a drop marker pre-empts pending records so that
    // anything written after a loss always follows the marker reporting it
    // ------------------------------------------------------------------
    always_comb begin
        drops_pending  = (drops_q != 8'd0);
        can_write      = (level_q != FULL_LEVEL) || fifo_rd;
        marker_push    = drops_pending && can_write;
        normal_push    = !drops_pending && sel_valid && can_write;
        fifo_wr        = marker_push || normal_push;
        // While losses are unreported the selected record is discarded
        // rather than queued behind (or ahead of) the marker.
        stage_drop     = drops_pending && sel_valid;
        pend_clear     = (drops_pending || normal_push) ? sel_mask : '0;
        marker_payload = '0;
        marker_payload[7:0] = drops_q;
        wr_entry       = marker_push ? {MARKER_HDR, marker_payload}
                                     : {RECORD_TAG, sel_id, sel_data};
    end

    // ------------------------------------------------------------------
    // Capture stage: load free (or freeing) registers, count the rest
    // ------------------------------------------------------------------
    always_comb begin
        load_mask     = '0;
        capture_drops = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (enable && log_strobe[c]) begin
                if (!pend_valid_q[c] || pend_clear[c]) begin
                    load_mask[c] = 1'b1;
                end else begin
                    capture_drops = capture_drops + 5'd1;
                end
            end
        end
        drop_total = capture_drops + {4'd0, stage_drop};
        // A marker hands off the current count; drops in the same cycle
        // start the next count.
        drops_sum  = (marker_push ? 9'd0 : {1'b0, drops_q}) + {4'd0, drop_total};
        drops_next = (drops_sum > 9'd255) ? 8'hFF : drops_sum[7:0];
    end

    // Pending-register occupancy and the saturating drop counter
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= '0;
            drops_q      <= 8'd0;
        end else begin
            pend_valid_q <= (pend_valid_q & ~pend_clear) | load_mask;
            drops_q      <= drops_next;
        end
    end

    // Pending payloads are qualified by pend_valid_q
    // NOTE: data storage is deliberately not reset; its contents are only
    // consumed under a valid flag or FIFO pointer that is reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (load_mask[c]) begin
                pend_data_q[c] <= log_data[c*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    // Storage write and registered read data
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_q] <= wr_entry;
        end
        if (fifo_rd) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Wrapping pointers and occupancy level
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, FIFO read request and byte strobe
    always_comb begin
        state_d   = state_q;
        fifo_rd   = 1'b0;
        send_byte = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    fifo_rd = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SEND;
            end
            SEND: begin
                if (uart_txd_ready) begin
                    send_byte = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                state_d = (bytes_left_q != '0) ? SEND : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register, remaining-byte count and last transmitted byte
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= '0;
            bytes_left_q <= '0;
            txd_hold_q   <= 8'd0;
        end else if (state_q == LOAD) begin
            shift_q      <= rd_data_q;
            bytes_left_q <= CNT_W'(RECORD_BYTES + 1);
        end else if (send_byte) begin
            txd_hold_q   <= shift_q[ENTRY_W-1 -: 8];
            shift_q      <= shift_q << 8;
            bytes_left_q <= bytes_left_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // A reset cycle suppresses the strobe even if the FSM is still in SEND.
    assign uart_txd_strobe = send_byte && !reset;
    // The byte about to go out is visible while waiting in SEND; afterwards
    // the last transmitted byte is held.
    assign uart_txd        = (state_q == SEND) ? shift_q[ENTRY_W-1 -: 8] : txd_hold_q;
    assign fifo_level      = level_q;
    assign drops           = drops_q;
    assign busy            = (state_q != IDLE) || (level_q != '0);

endmodule
